// File: rtl/mul_operand_sequencer_pkg.sv
// Shared types for the multiplier operand sequencer: FSM states, bus width
// and the queued operand pair.
package mul_operand_sequencer_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_OUT    = 3'd5,
    S_CLEAR  = 3'd6
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operand_t;

endpackage

// File: rtl/mul_operand_fifo.sv
// Operand-pair FIFO: power-of-two depth, registered occupancy count.
module mul_operand_fifo
  import mul_operand_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [2*DATA_W-1:0]     wr_data,
  input  logic                    rd_en,
  output logic [2*DATA_W-1:0]     rd_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wr_fire, rd_fire;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = wr_en && !full;
    rd_fire  = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (wr_fire) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds queued operand pairs to the repeated-addition multiplier (start, A, B),
// waits for done under a watchdog, and returns the product over valid/ready.
module mul_operand_sequencer
  import mul_operand_sequencer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_data,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_product,
  output logic              mul_clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_product,
  output logic              res_err
);

  localparam int                WDOG_W    = $clog2(TIMEOUT);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;
  logic [DATA_W-1:0]       res_product_q, res_product_d;
  logic                    res_err_q, res_err_d;
  logic                    pop;
  logic                    fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [2*DATA_W-1:0]     fifo_rd_data;
  operand_t                head;
  operand_t                in_pair;

  assign in_pair = '{a: in_a, b: in_b};
  assign head    = fifo_rd_data;

  mul_operand_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_pair),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready    = !fifo_full;
  assign res_product = res_product_q;
  assign res_err     = res_err_q;

  always_comb begin
    state_d       = state_q;
    wdog_d        = wdog_q;
    res_product_d = res_product_q;
    res_err_d     = res_err_q;
    mul_start     = 1'b0;
    mul_data      = '0;
    mul_clear     = 1'b0;
    res_valid     = 1'b0;
    pop           = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) state_d = S_START;
      end
      S_START: begin
        mul_start = 1'b1;
        state_d   = S_LOAD_A;
      end
      S_LOAD_A: begin
        mul_data = head.a;
        state_d  = S_LOAD_B;
      end
      S_LOAD_B: begin
        mul_data = head.b;
        pop      = !fifo_empty;
        wdog_d   = '0;
        state_d  = S_WAIT;
      end
      // done takes priority over an expiring watchdog in the same cycle
      S_WAIT: begin
        if (mul_done) begin
          res_product_d = mul_product;
          res_err_d     = 1'b0;
          state_d       = S_OUT;
        end else if (wdog_q == WDOG_LAST) begin
          res_product_d = '0;
          res_err_d     = 1'b1;
          state_d       = S_OUT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        mul_clear = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wdog_q        <= '0;
      res_product_q <= '0;
      res_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wdog_q        <= wdog_d;
      res_product_q <= res_product_d;
      res_err_q     <= res_err_d;
    end
  end

endmodule
